// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV64 core: fetch/decode/execute/memory/writeback sequencing.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.

module multicycle_ctrl
`ifdef MC_PERF_CNT_EN
#(
   parameter int CNT_W = 64
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_sel,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic       retire
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_cycles,
   output logic [CNT_W-1:0] perf_instret
`endif
);

   // state  | meaning
   // INIT   | one idle cycle after reset, all outputs 0
   // FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
   // DECODE | ALUOut <= old_pc + (imm<<1), dispatch on opcode
   // EXEC_R | rs1 op rs2 for R-type
   // R_WB   | write ALUOut to rd, retire
   // ADDR   | ALUOut <= rs1 + imm for ld/sd
   // MEM_RD | data read at ALUOut, wait for mem_ready
   // LD_WB  | write MDR to rd, retire
   // MEM_WR | data write at ALUOut, retire on mem_ready
   // BRANCH | compare rs1-rs2, take branch on zero, retire
   // TRAP   | unsupported opcode, parked until reset

   typedef enum logic [3:0] {
      INIT, FETCH, DECODE, EXEC_R, R_WB, ADDR, MEM_RD, LD_WB, MEM_WR, BRANCH, TRAP
   } state_t;

   localparam logic [6:0] OP_R   = 7'd51;
   localparam logic [6:0] OP_LD  = 7'd3;
   localparam logic [6:0] OP_SD  = 7'd35;
   localparam logic [6:0] OP_BEQ = 7'd99;

   state_t r_state;
   state_t w_state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= INIT;
      else        r_state <= w_state_nxt;
   end

   // Outputs decode from the state register so reset clears them immediately.
   always_comb begin
      w_state_nxt = r_state;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_sel     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      alu_src_a   = 2'd0;
      alu_src_b   = 2'd0;
      alu_op      = 2'b00;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      illegal     = 1'b0;
      retire      = 1'b0;
      case (r_state)
         INIT: w_state_nxt = FETCH;
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            if (mem_ready) begin
               ir_write    = 1'b1;
               pc_write    = 1'b1;
               w_state_nxt = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd3;
            case (opcode)
               OP_R:         w_state_nxt = EXEC_R;
               OP_LD, OP_SD: w_state_nxt = ADDR;
               OP_BEQ:       w_state_nxt = BRANCH;
               default:      w_state_nxt = TRAP;
            endcase
         end
         EXEC_R: begin
            alu_src_a   = 2'd2;
            alu_op      = 2'b10;
            w_state_nxt = R_WB;
         end
         R_WB: begin
            reg_write   = 1'b1;
            retire      = 1'b1;
            w_state_nxt = FETCH;
         end
         ADDR: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd2;
            if (opcode == OP_LD)      w_state_nxt = MEM_RD;
            else if (opcode == OP_SD) w_state_nxt = MEM_WR;
            else                      w_state_nxt = TRAP;
         end
         MEM_RD: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            if (mem_ready) w_state_nxt = LD_WB;
         end
         LD_WB: begin
            reg_write   = 1'b1;
            mem_to_reg  = 1'b1;
            retire      = 1'b1;
            w_state_nxt = FETCH;
         end
         MEM_WR: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = 1'b1;
            if (mem_ready) begin
               retire      = 1'b1;
               w_state_nxt = FETCH;
            end
         end
         BRANCH: begin
            alu_src_a   = 2'd2;
            alu_op      = 2'b01;
            pc_src      = 1'b1;
            pc_write    = zero;
            retire      = 1'b1;
            w_state_nxt = FETCH;
         end
         TRAP: illegal = 1'b1;
         default: w_state_nxt = INIT;
      endcase
   end

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] r_perf_cycles;
   logic [CNT_W-1:0] r_perf_instret;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_cycles  <= '0;
         r_perf_instret <= '0;
      end else begin
         if (r_state != INIT && r_state != TRAP) r_perf_cycles <= r_perf_cycles + CNT_W'(1);
         if (retire) r_perf_instret <= r_perf_instret + CNT_W'(1);
      end
   end

   assign perf_cycles  = r_perf_cycles;
   assign perf_instret = r_perf_instret;
`else
   // Performance counters are not built in this configuration.
`endif

endmodule
